// File: rtl/itree_path_scorer.sv
// Isolation-tree path-length scorer: walks one sample down a configurable binary
// tree, one node per cycle. Define ITREE_ANOM_CNT_EN to add the anom_count output.
module itree_path_scorer #(
  parameter int DATA_W   = 8,
  parameter int NUM_FEAT = 4,
  parameter int DEPTH    = 4,
  localparam int NODES   = 2**(DEPTH+1) - 1,
  localparam int AW      = $clog2(NODES),
  localparam int FW      = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1,
  localparam int LW      = $clog2(DEPTH+1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cfg_we,
  input  logic [AW-1:0]              cfg_addr,
  input  logic [FW-1:0]              cfg_feat,
  input  logic [DATA_W-1:0]          cfg_thresh,
  input  logic                       cfg_leaf,
  input  logic [LW-1:0]              score_thresh,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NUM_FEAT*DATA_W-1:0] data_input,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LW-1:0]              path_len,
  output logic                       anomaly_detected,
`ifdef ITREE_ANOM_CNT_EN
  output logic [15:0]                anom_count,
`endif
  output logic                       data_processed
);

  typedef struct packed {
    logic              leaf;
    logic [FW-1:0]     feat;
    logic [DATA_W-1:0] thresh;
  } node_t;

  typedef enum logic [1:0] {IDLE = 2'd0, TRAVERSE = 2'd1, DONE = 2'd2} state_t;

  state_t                     state;
  node_t                      tbl [NODES];
  logic [NUM_FEAT*DATA_W-1:0] sample;
  logic [AW-1:0]              node;
  logic [LW-1:0]              len;

  node_t             cur;
  logic [DATA_W-1:0] feat_val;
  logic              go_left, terminal;
  logic [AW-1:0]     node_nxt;

  // Out-of-range feature selects fall through to feature 0.
  always_comb begin
    cur      = tbl[node];
    feat_val = sample[DATA_W-1:0];
    for (int f = 0; f < NUM_FEAT; f++)
      if (cur.feat == FW'(f)) feat_val = sample[f*DATA_W +: DATA_W];
    go_left  = feat_val < cur.thresh;
    terminal = cur.leaf || (len == LW'(DEPTH));
    node_nxt = {node[AW-2:0], 1'b0} + (go_left ? AW'(1) : AW'(2));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      sample           <= '0;
      node             <= '0;
      len              <= '0;
      in_ready         <= 1'b1;
      out_valid        <= 1'b0;
      path_len         <= '0;
      anomaly_detected <= 1'b0;
      data_processed   <= 1'b0;
`ifdef ITREE_ANOM_CNT_EN
      anom_count       <= '0;
`endif
      for (int i = 0; i < NODES; i++) tbl[i] <= '{leaf: 1'b1, feat: '0, thresh: '0};
    end else begin
      data_processed <= 1'b0;
      case (state)
        IDLE: begin
          // Table writes land before the next traversal reads them.
          if (cfg_we && (cfg_addr < AW'(NODES)))
            tbl[cfg_addr] <= '{leaf: cfg_leaf, feat: cfg_feat, thresh: cfg_thresh};
          if (in_valid) begin
            sample   <= data_input;
            node     <= '0;
            len      <= '0;
            in_ready <= 1'b0;
            state    <= TRAVERSE;
          end
        end
        TRAVERSE: begin
          if (terminal) begin
            path_len         <= len;
            anomaly_detected <= len < score_thresh;
            out_valid        <= 1'b1;
            state            <= DONE;
          end else begin
            len  <= len + LW'(1);
            node <= node_nxt;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid      <= 1'b0;
            data_processed <= 1'b1;
            in_ready       <= 1'b1;
            state          <= IDLE;
`ifdef ITREE_ANOM_CNT_EN
            if (anomaly_detected && (anom_count != 16'hFFFF)) anom_count <= anom_count + 16'd1;
`endif
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
